// File: rtl/mul_job_sequencer.sv
// Queues operand pairs and drives one sequential multiplier job at a time, with a RUN watchdog.
// Latency: pop -> CLR -> GAP -> RUN(n) -> OUT, so Out_valid arrives n+3 cycles after the pop.
// Backpressure: In_ready drops when the FIFO is full; OUT holds its result until Out_ready.

module mul_job_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_vld,
    output logic         wr_rdy,
    input  logic [W-1:0] wr_dat,
    output logic         rd_vld,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat
);
    // Plain occupancy-counted FIFO.
    // Zero-latency read of the head entry; a write offered while full is dropped.
    // wr_rdy is the inverse of full; reads and writes in one cycle both complete.

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_wr;
    logic          do_rd;

    assign wr_rdy = (count != CW'(DEPTH));
    assign rd_vld = (count != '0);
    assign rd_dat = mem[rd_ptr];
    assign do_wr  = wr_vld && wr_rdy;
    assign do_rd  = rd_vld && rd_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            if (do_wr && !do_rd)      count <= count + CW'(1);
            else if (!do_wr && do_rd) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr && !reset) mem[wr_ptr] <= wr_dat;
    end
endmodule

module mul_job_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 128
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        In_valid,
    output logic        In_ready,
    input  logic [31:0] Multiplicand_in,
    input  logic [31:0] Multiplier_in,
    output logic        Mul_reset,
    output logic        Mul_run,
    output logic [31:0] Mul_multiplicand,
    output logic [31:0] Mul_multiplier,
    input  logic [63:0] Mul_product,
    input  logic        Mul_ready,
    output logic        Out_valid,
    input  logic        Out_ready,
    output logic [31:0] Hi_out,
    output logic [31:0] Lo_out,
    output logic        Err_out,
    output logic        Busy
);
    // Job sequencer in front of a sequential multiplier.
    // Latency: pop to Out_valid is CLR + GAP + RUN(n) + 1 cycles; RUN is capped at TIMEOUT cycles.
    // Backpressure: FIFO accepts in every state; OUT waits for Out_ready before the next pop.

    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, CLR, GAP, RUN, OUT} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          fifo_vld;
    logic [63:0]   fifo_dat;
    logic          pop;
    logic [31:0]   op_a;
    logic [31:0]   op_b;
    logic [WW-1:0] wd_cnt;
    logic          wd_done;
    logic          ready_q;
    logic          ready_rise;
    logic [31:0]   hi_q;
    logic [31:0]   lo_q;
    logic          err_q;

    mul_job_fifo #(
        .W     (64),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (Reset),
        .wr_vld (In_valid),
        .wr_rdy (In_ready),
        .wr_dat ({Multiplicand_in, Multiplier_in}),
        .rd_vld (fifo_vld),
        .rd_rdy (pop),
        .rd_dat (fifo_dat)
    );

    // Only a fresh 0->1 transition counts; a level left over from the last job does not.
    assign ready_rise = Mul_ready && !ready_q;
    assign wd_done    = (wd_cnt == WW'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        Mul_reset = 1'b0;
        Mul_run   = 1'b0;
        Out_valid = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_vld) begin
                    pop       = 1'b1;
                    state_nxt = CLR;
                end
            end
            CLR: begin
                Mul_reset = 1'b1;
                state_nxt = GAP;
            end
            GAP: begin
                state_nxt = RUN;
            end
            RUN: begin
                Mul_run = 1'b1;
                if (ready_rise || wd_done) state_nxt = OUT;
            end
            OUT: begin
                Out_valid = 1'b1;
                if (Out_ready) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state   <= IDLE;
            ready_q <= 1'b0;
            op_a    <= '0;
            op_b    <= '0;
            wd_cnt  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= Mul_ready;
            if (pop) begin
                op_a <= fifo_dat[63:32];
                op_b <= fifo_dat[31:0];
            end
            // Counter is held at zero outside RUN so each RUN entry starts fresh.
            if (state == RUN) wd_cnt <= wd_cnt + WW'(1);
            else              wd_cnt <= '0;
            if (state == RUN) begin
                if (ready_rise) begin
                    hi_q  <= Mul_product[63:32];
                    lo_q  <= Mul_product[31:0];
                    err_q <= 1'b0;
                end else if (wd_done) begin
                    hi_q  <= '0;
                    lo_q  <= '0;
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign Mul_multiplicand = op_a;
    assign Mul_multiplier   = op_b;
    assign Hi_out           = hi_q;
    assign Lo_out           = lo_q;
    assign Err_out          = err_q;
    assign Busy             = (state != IDLE) || fifo_vld;
endmodule

// File: doc/mul_job_sequencer.md
MUL_JOB_SEQUENCER -- requirements
Module: mul_job_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, operand-pair FIFO depth (power of two, at least 2).
REQ-002 Parameter TIMEOUT, default 128, maximum cycles spent in RUN before an error is flagged.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock; all state updates on its rising edge.
REQ-005 Reset  in  1  synchronous active-high reset.
REQ-006 In_valid  in  1  operand pair offered.
REQ-007 In_ready  out  1  FIFO not full; push occurs when In_valid and In_ready are both high.
REQ-008 Multiplicand_in  in  32  unsigned multiplicand.
REQ-009 Multiplier_in  in  32  unsigned multiplier.
REQ-010 Mul_reset  out  1  reset strobe to the sequential multiplier.
REQ-011 Mul_run  out  1  run request to the multiplier.
REQ-012 Mul_multiplicand / Mul_multiplier  out  32 each  operands to the multiplier.
REQ-013 Mul_product  in  64  multiplier product.
REQ-014 Mul_ready  in  1  multiplier done; only its rising edge is meaningful.
REQ-015 Out_valid  out  1  result available.
REQ-016 Out_ready  in  1  consumer accepts; transfer occurs when Out_valid and Out_ready are both high.
REQ-017 Hi_out / Lo_out  out  32 each  product[63:32] / product[31:0].
REQ-018 Err_out  out  1  result is a timeout error; valid only while Out_valid is high.
REQ-019 Busy  out  1  high in any state other than IDLE, or while the FIFO is non-empty.

Function
REQ-020 FIFO: DEPTH entries of 64 bits each, holding {multiplicand, multiplier}.
- Uses an occupancy counter.
- In_ready is the inverse of full.
- Push and pop in the same cycle are both performed and the count is unchanged.
- A push offered while full is ignored.
REQ-021 FSM states: IDLE, CLR, GAP, RUN, OUT.
REQ-022 IDLE:
- Moves to CLR when the FIFO is non-empty.
- On that transition the head entry is popped into an operand register, which drives Mul_multiplicand and Mul_multiplier.
REQ-023 CLR: Mul_reset=1 for exactly one cycle, then GAP.
REQ-024 GAP: Mul_reset=0 and Mul_run=0 for one cycle, then RUN.
REQ-025 RUN:
- Mul_run=1 throughout.
- A rising edge of Mul_ready (Mul_ready=1 while the registered previous value was 0) causes, in that cycle: capture of Mul_product into Hi_out/Lo_out, Err_out=0, then a move to OUT.
REQ-026 RUN watchdog:
- The cycle counter clears on entry to RUN.
- If the count reaches TIMEOUT with no rising edge, the block moves to OUT with Hi_out=0, Lo_out=0, Err_out=1.
REQ-027 A rising edge that arrives in the same cycle the count reaches TIMEOUT SHALL be treated as success.
REQ-028 Mul_ready held high on entry to RUN (stale level) SHALL NOT count as completion; a new 0-to-1 transition is required.
REQ-029 OUT:
- Mul_run=0 and Out_valid=1.
- Hi_out, Lo_out and Err_out stay stable until the transfer.
- On the transfer, go to IDLE.
REQ-030 Minimum job latency, from the pop to Out_valid: CLR + GAP + RUN(n) + 1 cycle, where n is the multiplier's cycle count.
REQ-031 Operand outputs SHALL stay constant from CLR until leaving RUN.
REQ-032 Out_ready asserted in any state other than OUT SHALL have no effect.
REQ-033 The FIFO SHALL continue accepting pushes in every FSM state.

Reset
REQ-034 While Reset=1, at the next clock edge the block SHALL set:
- FSM to IDLE; FIFO emptied, with pointers and count at 0.
- Operand register, Hi_out, Lo_out and Err_out to 0.
- Mul_reset=0, Mul_run=0, Out_valid=0, Busy=0, In_ready=1.
- Watchdog counter and previous-Mul_ready register to 0.
REQ-035 Reset in any state, including mid-RUN, SHALL abandon the job in progress and discard queued entries; no Out_valid is produced for them.
REQ-036 Pushes in a cycle where Reset=1 SHALL be ignored.

Verification
REQ-037 Push {3,5}, with the multiplier model asserting Mul_ready 33 cycles after Run:
- Exactly one Mul_reset pulse, then one idle cycle, then Mul_run held high.
- Out_valid with Hi_out=0x00000000, Lo_out=0x0000000F, Err_out=0.
REQ-038 Push {0xFFFFFFFF,0xFFFFFFFF} -> Hi_out=0xFFFFFFFE, Lo_out=0x00000001.
REQ-039 Five back-to-back pushes during a long job with DEPTH=4:
- In_ready drops after the fourth accepted push.
- The fifth push is held off until the first pop.
- All results come out in push order.
REQ-040 Out_ready held low for 10 cycles -> Out_valid and the data stay stable, with no further Mul_reset or Mul_run pulses; the next job starts only after the transfer.
REQ-041 Model never asserts Mul_ready -> after exactly TIMEOUT=128 RUN cycles, Out_valid=1, Err_out=1, Hi_out=0, Lo_out=0; the next queued job then runs normally.
REQ-042 Reset asserted mid-RUN with 2 jobs queued -> the next cycle shows In_ready=1, Busy=0 and no Out_valid; a new job pushed afterwards completes correctly.
